// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: word width, fetch FSM states
// and default reset/exception addresses.
package mips_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam logic [WORD_W-1:0] EXC_VECTOR_DEFAULT = 32'h8000_0180;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_HOLD
    } fetch_state_e;

    // Instruction addresses are word aligned; drop the byte offset.
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/incrementer.sv
// Sequential next-PC: PC + 4, wrapping modulo 2^32.
module incrementer
    import mips_pkg::*;
(
    input  logic [WORD_W-1:0] pcin,
    output logic [WORD_W-1:0] pcout
);

    assign pcout = pcin + WORD_W'(4);

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, arbitrates redirects and runs
// the imem request/grant/response handshake feeding decode.
module fetch_pc_ctrl
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [WORD_W-1:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    input  logic              jump,
    input  logic [WORD_W-1:0] jump_target,
    input  logic              exception,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic              if_valid,
    output logic [WORD_W-1:0] if_pc,
    output logic [WORD_W-1:0] if_instr,
    input  logic              if_ready
);

    fetch_state_e      state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_next;
    logic              kill;
    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;

    incrementer u_incrementer (
        .pcin  (pc),
        .pcout (pc_next)
    );

    // Redirect select: exception over jump over branch.
    always_comb begin
        redirect    = exception | jump | branch_taken;
        redirect_pc = branch_target;
        if (exception) begin
            redirect_pc = EXC_VECTOR;
        end else if (jump) begin
            redirect_pc = jump_target;
        end
        redirect_pc = word_align(redirect_pc);
    end

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH_IDLE;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            imem_req <= 1'b0;
            if_valid <= 1'b0;
            if_pc    <= RESET_PC;
            if_instr <= '0;
        end else begin
            if (redirect) begin
                pc <= redirect_pc;
            end
            case (state)
                FETCH_IDLE: begin
                    state    <= FETCH_REQ;
                    imem_req <= 1'b1;
                end
                FETCH_REQ: begin
                    // A redirect in the grant cycle makes the granted response stale.
                    if (imem_gnt) begin
                        state    <= FETCH_WAIT;
                        imem_req <= 1'b0;
                        kill     <= redirect;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill || redirect) begin
                            state    <= FETCH_REQ;
                            imem_req <= 1'b1;
                            kill     <= 1'b0;
                        end else begin
                            state    <= FETCH_HOLD;
                            if_valid <= 1'b1;
                            if_instr <= imem_rdata;
                            if_pc    <= pc;
                        end
                    end else if (redirect) begin
                        kill <= 1'b1;
                    end
                end
                FETCH_HOLD: begin
                    if (redirect || if_ready) begin
                        state    <= FETCH_REQ;
                        if_valid <= 1'b0;
                        imem_req <= 1'b1;
                        if (!redirect) begin
                            pc <= pc_next;
                        end
                    end
                end
                default: begin
                    state    <= FETCH_IDLE;
                    imem_req <= 1'b0;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed scenarios plus randomized traffic checked
// against a transaction-level model of the architectural PC and memory contents.
module tb_fetch_pc_ctrl;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exception;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;

    fetch_pc_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .exception     (exception),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_ready      (if_ready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned gnt_pct, rv_pct, spur_pct;
    bit          pending;
    logic [31:0] pend_addr;
    logic [31:0] exp_pc;
    int          accepted;
    bit          hold_prev;
    logic [31:0] prev_pc, prev_instr;

    // Memory contents: word at byte address a.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h2000_0001 + (a >> 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: memory responds, model advances, outputs checked at the falling edge.
    task automatic tick();
        logic [31:0] tgt;
        bit          redir;
        imem_gnt = ($urandom_range(99) < (imem_req ? gnt_pct : spur_pct));
        if (pending) begin
            imem_rvalid = ($urandom_range(99) < rv_pct);
            imem_rdata  = memf(pend_addr);
        end else begin
            imem_rvalid = ($urandom_range(99) < spur_pct);
            imem_rdata  = 32'hDEAD_BEEF;
        end
        redir = exception || jump || branch_taken;
        tgt   = exception ? 32'h8000_0180 : (jump ? jump_target : branch_target);
        tgt[1:0] = 2'b00;
        hold_prev  = if_valid && !if_ready && !redir;
        prev_pc    = if_pc;
        prev_instr = if_instr;
        if (redir) exp_pc = tgt;
        else if (if_valid && if_ready) exp_pc = exp_pc + 32'd4;
        if (if_valid && if_ready) accepted++;
        if (pending && imem_rvalid) pending = 1'b0;
        if (imem_req && imem_gnt) begin
            pending   = 1'b1;
            pend_addr = imem_addr;
        end
        @(posedge clk);
        @(negedge clk);
        chk("imem_addr", imem_addr, exp_pc);
        if (pending) chk("one_outstanding", 32'(imem_req), 32'd0);
        if (if_valid) begin
            chk("if_pc", if_pc, exp_pc);
            chk("if_instr", if_instr, memf(if_pc));
            chk("req_in_hold", 32'(imem_req), 32'd0);
        end
        if (hold_prev) begin
            chk("hold_valid", 32'(if_valid), 32'd1);
            chk("hold_pc", if_pc, prev_pc);
            chk("hold_instr", if_instr, prev_instr);
        end
    endtask

    task automatic clear_redirects();
        exception    = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_redirects();
        branch_target = '0;
        jump_target   = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        gnt_pct = 100; rv_pct = 100; spur_pct = 0;
        pending = 1'b0; exp_pc = 32'h0; accepted = 0; hold_prev = 1'b0;

        #3;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Steady fetch with decode always ready.
        if_ready = 1'b1;
        tick(); chk("first_req", 32'(imem_req), 32'd1); chk("first_addr", imem_addr, 32'h0);
        tick(); chk("wait_req", 32'(imem_req), 32'd0); chk("wait_valid", 32'(if_valid), 32'd0);
        tick(); chk("first_valid", 32'(if_valid), 32'd1);
        chk("first_pc", if_pc, 32'h0); chk("first_instr", if_instr, 32'h2000_0001);
        tick(); chk("second_req", 32'(imem_req), 32'd1); chk("second_addr", imem_addr, 32'h4);
        tick(); tick();
        chk("second_valid", 32'(if_valid), 32'd1);
        chk("second_pc", if_pc, 32'h4); chk("second_instr", if_instr, 32'h2000_0002);

        // Backpressure in HOLD.
        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(if_valid), 32'd1);
            chk("bp_pc", if_pc, 32'h4);
            chk("bp_req", 32'(imem_req), 32'd0);
        end
        if_ready = 1'b1;
        tick(); chk("bp_next_req", 32'(imem_req), 32'd1); chk("bp_next_addr", imem_addr, 32'h8);

        // Jump while awaiting the 0x8 response.
        rv_pct = 0;
        tick(); chk("wj_pending", 32'(pending), 32'd1); chk("wj_pend_addr", pend_addr, 32'h8);
        jump = 1'b1; jump_target = 32'h0000_0103;
        tick();
        clear_redirects();
        chk("wj_valid0", 32'(if_valid), 32'd0);
        rv_pct = 100;
        tick();
        chk("wj_dropped", 32'(if_valid), 32'd0);
        chk("wj_req", 32'(imem_req), 32'd1);
        chk("wj_addr", imem_addr, 32'h0000_0100);

        // All three redirects in HOLD.
        if_ready = 1'b0;
        for (int i = 0; i < 20 && !if_valid; i++) tick();
        chk("pri_hold", 32'(if_valid), 32'd1);
        exception = 1'b1; jump = 1'b1; branch_taken = 1'b1;
        jump_target = 32'h0000_0444; branch_target = 32'h0000_0888;
        tick();
        clear_redirects();
        chk("pri_addr", imem_addr, 32'h8000_0180);
        chk("pri_valid", 32'(if_valid), 32'd0);

        // Wrap-around from the top of the address space.
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
        tick();
        clear_redirects();
        for (int i = 0; i < 20 && !if_valid; i++) tick();
        chk("wrap_valid", 32'(if_valid), 32'd1);
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        if_ready = 1'b1;
        tick();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_req", 32'(imem_req), 32'd1);

        // Asynchronous reset while in WAIT; late response must be ignored.
        rv_pct = 0;
        for (int i = 0; i < 20 && !pending; i++) tick();
        chk("ar_pending", 32'(pending), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req", 32'(imem_req), 32'd0);
        chk("ar_valid", 32'(if_valid), 32'd0);
        chk("ar_addr", imem_addr, 32'h0);
        pending = 1'b0; exp_pc = 32'h0; hold_prev = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        gnt_pct = 0; spur_pct = 100;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ar_late_rvalid", 32'(if_valid), 32'd0);
        end

        // Randomized traffic.
        gnt_pct = 70; rv_pct = 60; spur_pct = 10; accepted = 0;
        for (int i = 0; i < 3000; i++) begin
            exception     = ($urandom_range(99) < 1);
            jump          = ($urandom_range(99) < 2);
            branch_taken  = ($urandom_range(99) < 3);
            jump_target   = $urandom;
            branch_target = $urandom;
            if_ready      = ($urandom_range(99) < 70);
            tick();
        end
        clear_redirects();
        chk("progress", 32'(accepted > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Instruction-fetch sequencer for the 32-bit MIPS core. It consumes the next-PC produced by the `incrementer` (PC + 4) and owns the architectural fetch PC register. It arbitrates that PC against branch, jump and exception redirects, and drives a request/grant/response handshake to instruction memory. Fetched words are presented to the decode stage with valid/ready flow control.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `EXC_VECTOR`, default 32'h8000_0180: exception redirect target.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous and active-low.
- `branch_taken`  in  1  redirect to `branch_target` this cycle.
- `branch_target`  in  32  branch destination.
- `jump`  in  1  redirect to `jump_target` this cycle.
- `jump_target`  in  32  jump destination.
- `exception`  in  1  redirect to `EXC_VECTOR` this cycle.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  32  fetch address; always equals the current PC.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  response instruction word.
- `if_valid`  out  1  `if_instr` and `if_pc` are valid.
- `if_pc`  out  32  PC of the presented instruction.
- `if_instr`  out  32  presented instruction.
- `if_ready`  in  1  decode accepts the presented instruction.

## Operation
- States:
  - IDLE: one cycle after reset release.
  - REQ: `imem_req` = 1.
  - WAIT: granted, awaiting `imem_rvalid`.
  - HOLD: `if_valid` = 1, awaiting `if_ready`.
- State transitions:
  - IDLE → REQ unconditionally.
  - REQ → WAIT on `imem_gnt`.
  - WAIT → HOLD on `imem_rvalid` when the kill flag is clear. Capture `if_instr` <= `imem_rdata` and `if_pc` <= PC.
  - WAIT → REQ on `imem_rvalid` when the kill flag is set. Discard the data and clear the kill flag.
  - HOLD → REQ on `if_valid && if_ready`. PC <= incrementer output (PC + 4).
- Redirect priority: `exception` > `jump` > `branch_taken`. The selected target has bits [1:0] forced to 00.
- Redirect is accepted in every state; PC <= target at the next edge. Per state:
  - IDLE: PC only.
  - REQ without `imem_gnt`: stay REQ. `imem_addr` shows the new PC next cycle.
  - REQ with `imem_gnt` in the same cycle: go WAIT with the kill flag set. The old-address response must be dropped.
  - WAIT: set the kill flag. A simultaneous `imem_rvalid` is dropped, and the FSM goes directly to REQ.
  - HOLD: `if_valid` deasserts next cycle; go REQ. If `if_ready` is high in the same cycle, the held instruction counts as accepted. The redirect target still overrides PC + 4.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No trap.
- `imem_gnt` outside REQ is ignored. `imem_rvalid` outside WAIT is ignored.
- At most one request is outstanding.

## Timing
- Reset values (asynchronous on `rst_n` = 0):
  - PC = `RESET_PC`
  - state = IDLE
  - kill flag = 0
  - `imem_req` = 0
  - `imem_addr` = `RESET_PC`
  - `if_valid` = 0
  - `if_pc` = `RESET_PC`
  - `if_instr` = 0
- All outputs are registered or decoded directly from state/PC. No combinational path from any input to any output.
- First `imem_req` is asserted in the 2nd cycle after `rst_n` rises.
- Latency with `imem_gnt` = 1 and `imem_rvalid` one cycle after grant:
  - request cycle N
  - response N+1
  - `if_valid` N+2
- Throughput with `if_ready` tied high: one instruction per 3 cycles.
- `imem_addr` and `imem_req` are stable while in REQ unless a redirect occurs.
- `if_pc` and `if_instr` are stable while `if_valid` = 1 and `if_ready` = 0.
- Reset mid-transaction aborts immediately. Any later `imem_rvalid` is ignored, because the FSM is in IDLE/REQ.

## Structure
- Shared package `mips_pkg` holds:
  - the fetch-state enum (IDLE, REQ, WAIT, HOLD)
  - `RESET_PC` and `EXC_VECTOR` defaults
  - the 32-bit word-width constant
- Sub-module: one instance of the existing `incrementer` (`pcin` = PC, `pcout` = next sequential PC).
- Redirect mux, FSM and output registers live in `fetch_pc_ctrl`.

## Test plan
- Reset then steady fetch. Stimulus: `imem_gnt` = 1, `imem_rvalid` one cycle after grant returning 32'h2000_0001 and then 32'h2000_0002, `if_ready` = 1. Required: `imem_addr` 0x0 then 0x4; `if_pc`/`if_instr` = 0x0/32'h2000_0001, then 0x4/32'h2000_0002; `if_valid` first high 4 cycles after `rst_n` rise.
- Backpressure. Stimulus: hold `if_ready` = 0 for 5 cycles in HOLD. Required: `if_valid`, `if_pc` and `if_instr` are unchanged and `imem_req` = 0 throughout; next request is at PC + 4 after `if_ready` = 1.
- Redirect in WAIT. Stimulus: `jump` = 1 with `jump_target` = 32'h0000_0103 while awaiting a response for 0x8. Required: the 0x8 response is dropped with no `if_valid`; next `imem_addr` = 32'h0000_0100.
- Priority. Stimulus: `exception`, `jump` and `branch_taken` all high in HOLD. Required: next `imem_addr` = 32'h8000_0180 and `if_valid` deasserts.
- Wrap-around. Stimulus: redirect to 32'hFFFF_FFFC and accept that instruction. Required: next `imem_addr` = 32'h0000_0000.
- Asynchronous reset asserted in WAIT. Required: `imem_req` = 0 and `if_valid` = 0 before the next clock edge; a late `imem_rvalid` produces no `if_valid`.
